// File: rtl/line_xfer_ctrl.sv
// Moves whole lines between the 32-entry line array and pmem: fill, write-back, flush-all.
// Latency: fill done 3 cycles after accept at zero wait; write-back/flush 2 cycles per entry.
// Backpressure: req_ready only in IDLE; pmem waits stretch WAIT states until pmem_resp.
module line_xfer_ctrl #(
    parameter int WIDTH    = 128,
    parameter int IDX_BITS = 5,
    parameter int ADDR_W   = 16
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                req_valid,
    input  logic [1:0]          req_op,
    input  logic [ADDR_W-1:0]   req_addr,
    output logic                req_ready,
    output logic                busy,
    output logic                done,
    output logic                arr_write,
    output logic [IDX_BITS-1:0] arr_index,
    output logic [WIDTH-1:0]    arr_datain,
    input  logic [WIDTH-1:0]    arr_dataout,
    output logic                pmem_read,
    output logic                pmem_write,
    output logic [ADDR_W-1:0]   pmem_address,
    output logic [WIDTH-1:0]    pmem_wdata,
    input  logic [WIDTH-1:0]    pmem_rdata,
    input  logic                pmem_resp
);

    localparam int TAG_W = ADDR_W - IDX_BITS - 4;

    localparam logic [1:0] OP_FILL  = 2'b00;
    localparam logic [1:0] OP_WB    = 2'b01;
    localparam logic [1:0] OP_FLUSH = 2'b10;

    typedef enum logic [2:0] {
        IDLE,
        WB_LATCH,
        WB_WAIT,
        FILL_WAIT,
        FILL_WR,
        DONE
    } state_t;

    state_t              state, state_nxt;
    logic [1:0]          op_q;
    logic [TAG_W-1:0]    tag_q;
    logic [IDX_BITS-1:0] idx_q;      // also the flush walk counter
    logic [WIDTH-1:0]    wdata_q;
    logic [WIDTH-1:0]    fill_q;
    logic                accept;
    logic                last_idx;
    logic                addr_offset_unused;

    // byte offset within a line never reaches memory; addresses are line aligned
    assign addr_offset_unused = ^req_addr[3:0];

    assign accept       = req_valid && (state == IDLE);
    assign last_idx     = (idx_q == {IDX_BITS{1'b1}});
    assign arr_index    = idx_q;
    assign arr_datain   = fill_q;
    assign pmem_wdata   = wdata_q;
    assign pmem_address = {tag_q, idx_q, 4'b0000};

    // state register
    always_ff @(posedge clk) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    // next-state and strobe decode
    always_comb begin
        state_nxt  = state;
        req_ready  = 1'b0;
        busy       = 1'b1;
        done       = 1'b0;
        arr_write  = 1'b0;
        pmem_read  = 1'b0;
        pmem_write = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                busy      = 1'b0;
                if (req_valid) begin
                    case (req_op)
                        OP_FILL:  state_nxt = FILL_WAIT;
                        OP_WB:    state_nxt = WB_LATCH;
                        OP_FLUSH: state_nxt = WB_LATCH;
                        default:  state_nxt = DONE;
                    endcase
                end
            end
            WB_LATCH: state_nxt = WB_WAIT;
            WB_WAIT: begin
                pmem_write = 1'b1;
                if (pmem_resp) begin
                    if (op_q == OP_FLUSH && !last_idx) state_nxt = WB_LATCH;
                    else                               state_nxt = DONE;
                end
            end
            FILL_WAIT: begin
                pmem_read = 1'b1;
                if (pmem_resp) state_nxt = FILL_WR;
            end
            FILL_WR: begin
                arr_write = 1'b1;
                state_nxt = DONE;
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                busy      = 1'b0;
                state_nxt = IDLE;
            end
        endcase
    end

    // request capture, line data capture and flush index advance
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            op_q    <= '0;
            tag_q   <= '0;
            idx_q   <= '0;
            wdata_q <= '0;
            fill_q  <= '0;
        end else begin
            if (accept) begin
                op_q  <= req_op;
                tag_q <= req_addr[ADDR_W-1:ADDR_W-TAG_W];
                idx_q <= (req_op == OP_FLUSH) ? '0 : req_addr[IDX_BITS+3:4];
            end
            if (state == WB_LATCH)
                wdata_q <= arr_dataout;
            if (state == FILL_WAIT && pmem_resp)
                fill_q <= pmem_rdata;
            if (state == WB_WAIT && pmem_resp && op_q == OP_FLUSH && !last_idx)
                idx_q <= idx_q + IDX_BITS'(1);
        end
    end

endmodule
